// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, ctrl/status bit
// positions and the register-select decode used by the address decoder.
package mmio_pkg;

  localparam logic [5:0] OFF_OUT0   = 6'h00;
  localparam logic [5:0] OFF_OUT1   = 6'h04;
  localparam logic [5:0] OFF_OUT2   = 6'h08;
  localparam logic [5:0] OFF_CTRL   = 6'h0C;
  localparam logic [5:0] OFF_IN0    = 6'h10;
  localparam logic [5:0] OFF_IN1    = 6'h14;
  localparam logic [5:0] OFF_STATUS = 6'h18;
  localparam logic [5:0] OFF_POP    = 6'h1C;
  localparam logic [5:0] OFF_STAMP  = 6'h20;

  localparam int CTRL_CAP_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 4;

  typedef enum logic [3:0] {
    REG_OUT0,
    REG_OUT1,
    REG_OUT2,
    REG_CTRL,
    REG_IN0,
    REG_IN1,
    REG_STATUS,
    REG_POP,
    REG_STAMP,
    REG_NONE
  } reg_sel_e;

  // Word index is addr[5:2]; the byte lane bits never take part in the decode.
  function automatic reg_sel_e decode_reg(input logic [3:0] word);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word == OFF_OUT0[5:2])   sel = REG_OUT0;
    if (word == OFF_OUT1[5:2])   sel = REG_OUT1;
    if (word == OFF_OUT2[5:2])   sel = REG_OUT2;
    if (word == OFF_CTRL[5:2])   sel = REG_CTRL;
    if (word == OFF_IN0[5:2])    sel = REG_IN0;
    if (word == OFF_IN1[5:2])    sel = REG_IN1;
    if (word == OFF_STATUS[5:2]) sel = REG_STATUS;
    if (word == OFF_POP[5:2])    sel = REG_POP;
    if (word == OFF_STAMP[5:2])  sel = REG_STAMP;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_event_fifo.sv
// Small event FIFO with combinational head output; a push into a full FIFO succeeds
// only when a pop happens on the same edge, otherwise the entry is refused.
module mmio_event_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, the pop frees the slot the pointer is about to overwrite.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: output ports, ctrl/status, synchronized inputs and an in_port0 change
// FIFO. Define MMIO_TIMESTAMP_EN to stamp each captured event with a cycle count.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = 32'h0000_0080,
  parameter int          DATA_W      = 32,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [DATA_W-1:0] in_port0,
  input  logic [DATA_W-1:0] in_port1,
  output logic [DATA_W-1:0] out_port0,
  output logic [DATA_W-1:0] out_port1,
  output logic [DATA_W-1:0] out_port2,
  output logic              irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + 32;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic [DATA_W-1:0] sync0_reg [SYNC_STAGES];
  logic [DATA_W-1:0] sync1_reg [SYNC_STAGES];
  logic [DATA_W-1:0] synced0;
  logic [DATA_W-1:0] synced1;
  logic [DATA_W-1:0] prev0_reg;

  logic [DATA_W-1:0] out0_reg;
  logic [DATA_W-1:0] out1_reg;
  logic [DATA_W-1:0] out2_reg;
  logic [1:0]        ctrl_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  logic              irq_reg;

  reg_sel_e          sel;
  logic              wr_en;
  logic              rd_en;
  logic              change;
  logic              ovf_set;
  logic              ovf_clr;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] stamp_val;
  logic              unused_addr_bits;

  logic              fifo_push;
  logic              fifo_pop;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign hit              = (addr[31:6] == IO_BASE[31:6]);
  assign sel              = decode_reg(addr[5:2]);
  assign wr_en            = we & hit;
  assign rd_en            = re & hit & ~we;
  assign unused_addr_bits = ^addr[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync0_reg[i] <= '0;
        sync1_reg[i] <= '0;
      end
    end else begin
      sync0_reg[0] <= in_port0;
      sync1_reg[0] <= in_port1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync0_reg[i] <= sync0_reg[i-1];
        sync1_reg[i] <= sync1_reg[i-1];
      end
    end
  end

  assign synced0 = sync0_reg[SYNC_STAGES-1];
  assign synced1 = sync1_reg[SYNC_STAGES-1];
  assign change  = (synced0 != prev0_reg);

  assign fifo_push = ctrl_reg[CTRL_CAP_EN] & change;
  assign fifo_pop  = rd_en & (sel == REG_POP);
  // A full FIFO only drops the event when nothing is draining it on the same edge.
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
  assign ovf_clr   = wr_en & (sel == REG_CTRL) & wdata[CTRL_OVF_CLR];

  mmio_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MMIO_TIMESTAMP_EN
  logic [31:0] ts_reg;
  logic [31:0] last_stamp_reg;

  assign fifo_din = {ts_reg, synced0};

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_reg         <= '0;
      last_stamp_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 32'd1;
      if (fifo_pop && !fifo_empty) last_stamp_reg <= fifo_dout[ENTRY_W-1:DATA_W];
    end
  end

  assign stamp_val = DATA_W'(last_stamp_reg);
`else
  assign fifo_din  = synced0;
  assign stamp_val = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_OUT0:   rd_mux = out0_reg;
      REG_OUT1:   rd_mux = out1_reg;
      REG_OUT2:   rd_mux = out2_reg;
      REG_CTRL:   rd_mux[CTRL_IRQ_EN:CTRL_CAP_EN] = ctrl_reg;
      REG_IN0:    rd_mux = synced0;
      REG_IN1:    rd_mux = synced1;
      REG_STATUS: begin
        rd_mux[STAT_NONEMPTY] = ~fifo_empty;
        rd_mux[STAT_FULL]     = fifo_full;
        rd_mux[STAT_OVERFLOW] = overflow_reg;
        rd_mux[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      end
      REG_POP:    rd_mux = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
      REG_STAMP:  rd_mux = stamp_val;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out0_reg     <= '0;
      out1_reg     <= '0;
      out2_reg     <= '0;
      ctrl_reg     <= '0;
      prev0_reg    <= '0;
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      prev0_reg  <= synced0;
      rvalid_reg <= rd_en;
      if (rd_en) rdata_reg <= rd_mux;
      irq_reg <= ctrl_reg[CTRL_IRQ_EN] & ~fifo_empty;
      if (wr_en) begin
        case (sel)
          REG_OUT0: out0_reg <= wdata;
          REG_OUT1: out1_reg <= wdata;
          REG_OUT2: out2_reg <= wdata;
          REG_CTRL: ctrl_reg <= {wdata[CTRL_IRQ_EN], wdata[CTRL_CAP_EN]};
          default:  ;
        endcase
      end
      // A fresh drop on the same edge as a clear leaves the flag set.
      if (ovf_set)      overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  assign out_port0 = out0_reg;
  assign out_port1 = out1_reg;
  assign out_port2 = out2_reg;
  assign rdata     = rdata_reg;
  assign rvalid    = rvalid_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: queue-based register/FIFO model checked every cycle,
// plus directed transactions with literal expectations.
module tb_mmio_port_responder;

  localparam int          DATA_W      = 32;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          SYNC_STAGES = 2;
  localparam logic [31:0] IO_BASE     = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic [31:0] out_port0, out_port1, out_port2;
  logic        irq;

  always #5 clock = ~clock;

  mmio_port_responder #(
    .IO_BASE     (IO_BASE),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .hit       (hit),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .irq       (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out [3];
  logic [1:0]  m_ctrl;
  logic        m_ovf;
  logic [31:0] m_q [$];
  logic [31:0] m_h0 [$];
  logic [31:0] m_h1 [$];
  logic [31:0] m_prev0;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_irq;
  logic [31:0] m_ts;
  logic [31:0] m_last;
  logic [31:0] m_sq [$];

  function automatic logic [31:0] m_read(input logic [3:0] word);
    case (word)
      4'h0: return m_out[0];
      4'h1: return m_out[1];
      4'h2: return m_out[2];
      4'h3: return {30'b0, m_ctrl};
      4'h4: return m_h0[SYNC_STAGES-1];
      4'h5: return m_h1[SYNC_STAGES-1];
      4'h6: return {24'b0, 4'(m_q.size()), 1'b0, m_ovf,
                    (m_q.size() == FIFO_DEPTH), (m_q.size() != 0)};
      4'h7: return (m_q.size() != 0) ? m_q[0] : 32'h0;
`ifdef MMIO_TIMESTAMP_EN
      4'h8: return m_last;
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    logic        m_hit, wr, rd, pop, chg;
    logic [31:0] s0;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_out[i] = '0;
      m_ctrl = '0; m_ovf = 1'b0; m_prev0 = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
      m_ts = '0; m_last = '0;
      m_q.delete(); m_sq.delete(); m_h0.delete(); m_h1.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        m_h0.push_back('0);
        m_h1.push_back('0);
      end
    end else begin
      m_hit = (addr[31:6] == IO_BASE[31:6]);
      wr    = we && m_hit;
      rd    = re && m_hit && !we;
      s0    = m_h0[SYNC_STAGES-1];
      chg   = m_ctrl[0] && (s0 != m_prev0);
      pop   = rd && (addr[5:2] == 4'h7) && (m_q.size() != 0);
      m_irq    = m_ctrl[1] && (m_q.size() != 0);
      m_rvalid = rd;
      if (rd) m_rdata = m_read(addr[5:2]);
      if (wr) begin
        case (addr[5:2])
          4'h0: m_out[0] = wdata;
          4'h1: m_out[1] = wdata;
          4'h2: m_out[2] = wdata;
          4'h3: begin
            m_ctrl = wdata[1:0];
            if (wdata[2]) m_ovf = 1'b0;
          end
          default: ;
        endcase
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_last = m_sq.pop_front();
      end
      if (chg) begin
        if (m_q.size() < FIFO_DEPTH) begin
          m_q.push_back(s0);
          m_sq.push_back(m_ts);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev0 = s0;
      m_h0.push_front(in_port0); void'(m_h0.pop_back());
      m_h1.push_front(in_port1); void'(m_h1.pop_back());
      m_ts = m_ts + 32'd1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("hit", {31'b0, hit}, {31'b0, (addr[31:6] == IO_BASE[31:6])});
      check("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      check("rdata", rdata, m_rdata);
      check("out_port0", out_port0, m_out[0]);
      check("out_port1", out_port1, m_out[1]);
      check("out_port2", out_port2, m_out[2]);
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    step();
    we = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    addr = a; re = 1'b1; we = 1'b0;
    step();
    re = 1'b0;
    d = rdata;
    v = rvalid;
    $display("read  addr=%h data=%h rvalid=%0b", a, d, v);
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    rd(a, d, v);
    check({name, "_rvalid"}, {31'b0, v}, 32'h1);
    check(name, d, exp);
  endtask

  task automatic change0(input logic [31:0] val);
    in_port0 = val;
    idle(4);
  endtask

  initial begin
    logic [31:0] d;
    logic        v;

    reset = 1'b1;
    step();
    chk_en = 1'b1;
    idle(2);
    reset = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_out0", out_port0, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    // Output register write and readback
    wr(32'h84, 32'h1234_5678);
    check("out_port1_written", out_port1, 32'h1234_5678);
    rd_check("rd_out1", 32'h84, 32'h1234_5678);
    addr = 32'h100;
    #1;
    check("hit_outside", {31'b0, hit}, 32'h0);
    rd(32'h100, d, v);
    check("rvalid_outside", {31'b0, v}, 32'h0);
    wr(32'h98, 32'hFFFF_FFFF);
    rd_check("status_ro", 32'h98, 32'h0);
    rd_check("unmapped", 32'hBC, 32'h0);

    // Input synchronizer latency
    in_port1 = 32'hA5;
    rd_check("in1_early", 32'h94, 32'h0);
    step();
    rd_check("in1_synced", 32'h94, 32'hA5);

    // Event capture with interrupt
    wr(32'h8C, 32'h3);
    change0(32'd1);
    change0(32'd2);
    change0(32'd3);
    rd_check("status_3", 32'h98, 32'h31);
    check("irq_set", {31'b0, irq}, 32'h1);
    rd_check("pop_1", 32'h9C, 32'd1);
    rd_check("pop_2", 32'h9C, 32'd2);
    rd_check("pop_3", 32'h9C, 32'd3);
    rd_check("pop_empty", 32'h9C, 32'd0);
    check("irq_clear", {31'b0, irq}, 32'h0);

    // Overflow and clear
    wr(32'h8C, 32'h1);
    change0(32'd4);
    change0(32'd5);
    change0(32'd6);
    change0(32'd7);
    change0(32'd8);
    rd_check("status_ovf", 32'h98, 32'h47);
    wr(32'h8C, 32'h5);
    rd_check("status_ovf_clr", 32'h98, 32'h43);
    rd_check("ctrl_rb", 32'h8C, 32'h1);

    // Push and pop on the same edge while full: in_port0 lands in the FIFO 3 edges later
    in_port0 = 32'd9;
    step();
    step();
    rd_check("pop_while_push", 32'h9C, 32'd4);
    rd_check("status_full_kept", 32'h98, 32'h43);
    rd_check("pop_5", 32'h9C, 32'd5);
    rd_check("pop_6", 32'h9C, 32'd6);
    rd_check("pop_7", 32'h9C, 32'd7);
    rd_check("pop_tail", 32'h9C, 32'd9);
    rd_check("status_drained", 32'h98, 32'h0);

    // Reset in the middle of activity
    wr(32'h8C, 32'h3);
    wr(32'h80, 32'hDEAD_BEEF);
    wr(32'h88, 32'h0000_00C3);
    change0(32'd10);
    change0(32'd11);
    rd_check("status_2", 32'h98, 32'h21);
    check("irq_before_reset", {31'b0, irq}, 32'h1);
    addr = 32'h9C; re = 1'b1; reset = 1'b1;
    step();
    check("mid_reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("mid_reset_out0", out_port0, 32'h0);
    check("mid_reset_out1", out_port1, 32'h0);
    check("mid_reset_out2", out_port2, 32'h0);
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0; re = 1'b0;
    rd_check("status_after_reset", 32'h98, 32'h0);
    rd_check("ctrl_after_reset", 32'h8C, 32'h0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
